// File: rtl/goertzel_ctrl_pkg.sv
// goertzel_ctrl_pkg: shared state encoding and default sizing for the goertzel frame controller
package goertzel_ctrl_pkg;
    localparam int BLOCK_LEN_DEF = 5200;
    localparam int NUM_BINS_DEF  = 4;
    localparam int TIMEOUT_DEF   = 64;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FINISH, WAIT, EMIT} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for level flags entering the sample clock domain
module sync_2ff (
    input  logic clock_sample,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clock_sample) begin
        if (!reset_n) {q, meta} <= 2'b00;
        else          {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/goertzel_frame_ctrl.sv
// goertzel_frame_ctrl: frame sequencer and round-robin bin scheduler for a shared goertzel core
module goertzel_frame_ctrl
    import goertzel_ctrl_pkg::*;
#(
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int NUM_BINS  = NUM_BINS_DEF,
    parameter int BIN_W     = 2,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clock_sample,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear_err,
    input  logic [31:0]       sample_in,
    output logic [31:0]       core_sample,
    output logic              core_sample_valid,
    output logic              core_clear,
    output logic              core_finish,
    output logic [BIN_W-1:0]  core_coeff_sel,
    input  logic              core_done,
    input  logic [63:0]       core_power,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [63:0]       res_power,
    output logic [BIN_W-1:0]  res_bin,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int SW = $clog2(BLOCK_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0]    LAST_SAMPLE = SW'(BLOCK_LEN - 1);
    localparam logic [TW-1:0]    LAST_TMO    = TW'(TIMEOUT - 1);
    localparam logic [BIN_W-1:0] LAST_BIN    = BIN_W'(NUM_BINS - 1);

    state_t          state, state_nxt;
    logic [SW-1:0]   sample_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            done_s, next_run, slot_free;
    logic            advance, load, set_ovr, set_tmo;

    sync_2ff u_done_sync (
        .clock_sample (clock_sample),
        .reset_n      (reset_n),
        .d            (core_done),
        .q            (done_s)
    );

    assign busy      = state != IDLE;
    assign next_run  = enable;
    assign slot_free = !res_valid || res_ready;

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        load      = 1'b0;
        set_ovr   = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            IDLE:   state_nxt = enable ? CLEAR : IDLE;
            CLEAR:  state_nxt = ACCUM;
            ACCUM:  state_nxt = (sample_cnt == LAST_SAMPLE) ? FINISH : ACCUM;
            FINISH: state_nxt = WAIT;
            WAIT: begin
                set_tmo   = !done_s && tmo_cnt == LAST_TMO;
                advance   = set_tmo;
                state_nxt = done_s ? EMIT : set_tmo ? (next_run ? CLEAR : IDLE) : WAIT;
            end
            EMIT: begin
                advance   = 1'b1;
                load      = slot_free;
                set_ovr   = !slot_free;
                state_nxt = next_run ? CLEAR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Core-facing strobes are registered so clear, samples and finish reach the core in order.
    always_ff @(posedge clock_sample) begin
        if (!reset_n) begin
            state             <= IDLE;
            sample_cnt        <= '0;
            tmo_cnt           <= '0;
            core_sample       <= '0;
            core_sample_valid <= 1'b0;
            core_clear        <= 1'b0;
            core_finish       <= 1'b0;
            core_coeff_sel    <= '0;
            res_valid         <= 1'b0;
            res_power         <= '0;
            res_bin           <= '0;
            overrun           <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            state             <= state_nxt;
            sample_cnt        <= (state == ACCUM) ? sample_cnt + 1'b1 : '0;
            tmo_cnt           <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
            core_sample       <= (state == ACCUM) ? sample_in : core_sample;
            core_sample_valid <= state == ACCUM;
            core_clear        <= state == CLEAR;
            core_finish       <= state == FINISH;
            if (advance) core_coeff_sel <= (core_coeff_sel == LAST_BIN) ? '0 : core_coeff_sel + 1'b1;
            if (load) begin
                res_valid <= 1'b1;
                res_power <= core_power;
                res_bin   <= core_coeff_sel;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            overrun     <= set_ovr || (overrun && !clear_err);
            timeout_err <= set_tmo || (timeout_err && !clear_err);
        end
    end
endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// tb_goertzel_frame_ctrl: scoreboard bench with a behavioural core that raises done 3 cycles after finish
module tb_goertzel_frame_ctrl;
    localparam int BL = 8;
    localparam int NB = 3;
    localparam int BW = 2;
    localparam int TMO = 16;

    typedef struct packed {
        logic [63:0]   pwr;
        logic [BW-1:0] bin;
    } exp_t;

    logic          clock_sample = 1'b0;
    logic          reset_n, enable, clear_err, res_ready, core_done;
    logic [31:0]   sample_in, core_sample;
    logic          core_sample_valid, core_clear, core_finish;
    logic [BW-1:0] core_coeff_sel, res_bin;
    logic [63:0]   core_power, res_power;
    logic          res_valid, busy, overrun, timeout_err;
    logic          no_done;
    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];

    goertzel_frame_ctrl #(.BLOCK_LEN(BL), .NUM_BINS(NB), .BIN_W(BW), .TIMEOUT(TMO)) dut (
        .clock_sample      (clock_sample),
        .reset_n           (reset_n),
        .enable            (enable),
        .clear_err         (clear_err),
        .sample_in         (sample_in),
        .core_sample       (core_sample),
        .core_sample_valid (core_sample_valid),
        .core_clear        (core_clear),
        .core_finish       (core_finish),
        .core_coeff_sel    (core_coeff_sel),
        .core_done         (core_done),
        .core_power        (core_power),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_power         (res_power),
        .res_bin           (res_bin),
        .busy              (busy),
        .overrun           (overrun),
        .timeout_err       (timeout_err)
    );

    initial forever #5 clock_sample = ~clock_sample;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_sample);
        #1;
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return core_finish;
            1:       return res_valid;
            2:       return !busy;
            3:       return core_clear;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_for(input int k, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!sig(k) && n < 200);
        chk({"wait_", nm}, {63'd0, sig(k)}, 64'd1);
    endtask

    task automatic push(input logic [63:0] p, input logic [BW-1:0] b);
        core_power = p;
        sb.push_back('{pwr: p, bin: b});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, {57'd0, core_clear, core_finish, core_sample_valid, res_valid, busy, overrun, timeout_err}, 64'd0);
        chk({tag, "_sample"}, {32'd0, core_sample}, 64'd0);
        chk({tag, "_power"}, res_power, 64'd0);
        chk({tag, "_bins"}, {60'd0, res_bin, core_coeff_sel}, 64'd0);
    endtask

    // Free-running sample source: each cycle carries a distinct value, wrapping through zero.
    initial begin
        sample_in = 32'hFFFF_FFF0;
        forever begin
            tick();
            sample_in = sample_in + 32'd1;
        end
    end

    // Core model: done rises 3 cycles after a finish pulse and holds until clear.
    initial begin
        int fcnt = 0;
        core_done = 1'b0;
        forever begin
            tick();
            if (!reset_n || core_clear) begin
                core_done = 1'b0;
                fcnt = 0;
            end else if (core_finish && !no_done) begin
                fcnt = 1;
            end else if (fcnt != 0) begin
                fcnt++;
                if (fcnt == 4) begin
                    core_done = 1'b1;
                    fcnt = 0;
                end
            end
        end
    end

    // Monitor: scoreboard pops on handshake, plus per-frame core interface checks.
    initial begin
        exp_t          e;
        int            vcnt = 0;
        logic [BW-1:0] sel0 = '0;
        logic          clr_d = 1'b0;
        logic [31:0]   exp_s;
        forever begin
            @(negedge clock_sample);
            if (reset_n) begin
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", {62'd0, res_bin}, 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("res_power", res_power, e.pwr);
                        chk("res_bin", {62'd0, res_bin}, {62'd0, e.bin});
                    end
                end
                if (core_clear) begin
                    chk("clear_single", {63'd0, clr_d}, 64'd0);
                    vcnt = 0;
                    sel0 = core_coeff_sel;
                end
                if (core_sample_valid) begin
                    vcnt++;
                    exp_s = sample_in - 32'd1;
                    chk("sample_delay", {32'd0, core_sample}, {32'd0, exp_s});
                    chk("coeff_stable", {62'd0, core_coeff_sel}, {62'd0, sel0});
                end
                if (core_finish) chk("valid_count", 64'(vcnt), 64'(BL));
                clr_d = core_clear;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        enable = 1'b1;
        clear_err = 1'b0;
        res_ready = 1'b1;
        no_done = 1'b0;
        core_power = '0;
        repeat (4) tick();
        chk_reset("reset");
        reset_n = 1'b1;

        wait_for(0, "finish_f1");
        push(64'h0000_0000_0001_E240, 2'd0);
        wait_for(1, "result_f1");

        for (int i = 1; i <= 3; i++) begin
            wait_for(0, "finish_rr");
            push(64'h100 + 64'(i), BW'(i % NB));
        end
        wait_for(1, "result_f4");
        tick();
        res_ready = 1'b0;

        wait_for(0, "finish_f5");
        push(64'h11, 2'd1);
        wait_for(0, "finish_f6");
        core_power = 64'h22;
        enable = 1'b0;
        wait_for(2, "idle_ovr");
        chk("ovr_valid", {63'd0, res_valid}, 64'd1);
        chk("ovr_power_kept", res_power, 64'h11);
        chk("ovr_bin_kept", {62'd0, res_bin}, 64'd1);
        chk("ovr_flag", {63'd0, overrun}, 64'd1);
        res_ready = 1'b1;
        tick();
        chk("ovr_drained", {63'd0, res_valid}, 64'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ovr_cleared", {63'd0, overrun}, 64'd0);

        no_done = 1'b1;
        enable = 1'b1;
        wait_for(0, "finish_tmo");
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(TMO));
        chk("timeout_no_result", {63'd0, res_valid}, 64'd0);
        no_done = 1'b0;
        wait_for(3, "clear_after_tmo");
        chk("bin_after_tmo", {62'd0, core_coeff_sel}, 64'd1);
        chk("timeout_sticky", {63'd0, timeout_err}, 64'd1);
        wait_for(0, "finish_f8");
        push(64'h55, 2'd1);
        enable = 1'b0;
        wait_for(2, "idle_f8");
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("timeout_cleared", {63'd0, timeout_err}, 64'd0);

        enable = 1'b1;
        wait_for(3, "clear_f9");
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        chk_reset("midreset");
        reset_n = 1'b1;
        wait_for(3, "clear_f10");
        repeat (4) tick();
        enable = 1'b0;
        wait_for(0, "finish_f10");
        push(64'h77, 2'd0);
        wait_for(2, "idle_f10");
        tick();
        chk("final_drained", {63'd0, res_valid}, 64'd0);
        repeat (2) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
